hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline control unit for the 5-stage MIPS core. It generates the write-enable and flush controls for the PC and the IF/ID pipeline register, and the bubble control for ID/EX. It resolves load-use hazards, taken branches (resolved in EX), jumps (resolved in ID) and instruction-memory wait states. It also keeps saturating stall and flush counters for performance debug.

Parameters:
TIMEOUT, 16, max consecutive imem_ready-low cycles before fetch_err is raised (valid range 1..255)
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-low reset
ID_rs  input  5  rs field of the instruction in IF/ID
ID_rt  input  5  rt field of the instruction in IF/ID
ID_uses_rt  input  1  instruction in ID reads rt as a source
ID_jump  input  1  jump decoded in ID
EX_mem_read  input  1  instruction in EX is a load
EX_rt  input  5  destination (rt) of the load in EX
EX_branch_taken  input  1  branch in EX resolved taken
imem_ready  input  1  instruction memory has valid data this cycle
pc_write  output  1  PC register load enable
if_id_write  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID synchronous clear to NOP
id_ex_bubble  output  1  ID/EX control bits forced to zero
fetch_err  output  1  sticky imem timeout flag
stall_cnt  output  CNT_W  cycles with pc_write=0, saturating
flush_cnt  output  CNT_W  cycles with if_id_flush=1, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=RUN; flush_pend=0; wait_cnt=0; fetch_err=0; both counters=0. While rst=0 the outputs are forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
- Outputs are Mealy: combinational from the registered state plus current inputs. State and counters update on the rising clk edge. Zero-cycle latency from hazard to control.
- load_use = EX_mem_read & (EX_rt != 0) & ((EX_rt == ID_rs) | (ID_uses_rt & (EX_rt == ID_rt))).
- Priority per cycle, highest first:
  1. state ERR: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
  2. EX_branch_taken: pc_write=1, if_id_flush=1, id_ex_bubble=1. If imem_ready=0 this cycle, set flush_pend=1.
  3. imem_ready=0: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  4. flush_pend=1 with imem_ready=1: pc_write=1, if_id_flush=1 (the stale word is discarded), id_ex_bubble=1. flush_pend clears at the clock edge.
  5. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, exactly one cycle per hazard instance.
  6. ID_jump: pc_write=1, if_id_flush=1, id_ex_bubble=0.
  7. Default: pc_write=1, if_id_write=1, others 0.
- Whenever if_id_flush=1, if_id_write is don't-care; drive it 1.
- FSM states and transitions:
  - RUN -> WAIT when imem_ready=0.
  - WAIT -> RUN when imem_ready=1.
  - WAIT -> ERR when imem_ready has been low for TIMEOUT consecutive cycles.
  - ERR is terminal until reset; fetch_err=1 while in ERR.
- wait_cnt increments each cycle imem_ready=0 and clears to 0 on imem_ready=1.
- Counters: stall_cnt increments on every post-reset cycle with pc_write=0, including ERR; flush_cnt increments on every cycle with if_id_flush=1. Both saturate at all-ones and never wrap.
- Simultaneous branch and load_use: the branch wins and no stall cycle is spent.
- Simultaneous jump and load_use: the stall wins. The jump is re-presented next cycle because IF/ID is held.
- Reset asserted mid-WAIT or with flush_pend set: all pending state is discarded immediately.

Test Plan:
- Load-use: EX_mem_read=1, EX_rt=8, ID_rs=8, imem_ready=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cnt=1. With EX_rt=0 instead -> no stall.
- rt-only hazard: EX_rt=9, ID_rt=9, ID_uses_rt=0 -> no stall. Same with ID_uses_rt=1 -> one stall cycle.
- Branch during memory wait: imem_ready=0 for 3 cycles, EX_branch_taken=1 in cycle 2 -> pc_write=1 in cycle 2, flush_pend set; on the first imem_ready=1 cycle, if_id_flush=1; following cycle normal; flush_cnt=2.
- Timeout: TIMEOUT=4, hold imem_ready=0 -> state ERR and fetch_err=1 after the 4th low cycle. Raising imem_ready afterwards keeps fetch_err=1 and pc_write=0 until rst=0.
- Jump vs load_use in the same cycle -> cycle 1 stall (no flush); cycle 2 with load_use deasserted -> if_id_flush=1, pc_write=1.
- Async reset: drive rst=0 mid-WAIT, between clock edges -> outputs and counters reach reset values with no clock edge; after rst=1 with imem_ready=1 -> pc_write=1, if_id_write=1.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: PC and IF/ID write/flush, ID/EX bubble,
// imem wait-state tracking with timeout, and saturating stall/flush counters.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_jump,
  input  logic             EX_mem_read,
  input  logic [4:0]       EX_rt,
  input  logic             EX_branch_taken,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             fetch_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt;
  logic       flush_pend;
  logic       lu_block;
  logic       load_use_raw;
  logic       lu_stall;

  assign load_use_raw = EX_mem_read && (EX_rt != 5'd0) &&
                        ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  assign fetch_err = (state == S_ERR);

  // lu_block masks a hazard that was already served its single stall cycle
  // and is still being presented (IF/ID held, EX not yet advanced).
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    lu_stall     = 1'b0;
    if (!rst || state == S_ERR) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (EX_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (!imem_ready) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (flush_pend) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use_raw && !lu_block) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      lu_stall     = 1'b1;
    end else if (ID_jump) begin
      if_id_flush  = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state != S_ERR) begin
      if (!imem_ready) state_nxt = (wait_cnt >= TO_LAST) ? S_ERR : S_WAIT;
      else             state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RUN;
      wait_cnt   <= 8'd0;
      flush_pend <= 1'b0;
      lu_block   <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      lu_block <= load_use_raw && (lu_block || lu_stall);
      if (state != S_ERR) begin
        if (imem_ready) begin
          wait_cnt   <= 8'd0;
          flush_pend <= 1'b0;
        end else begin
          wait_cnt   <= wait_cnt + 8'd1;
          // a branch taken while fetch is stalled must flush the word that arrives later
          flush_pend <= flush_pend || EX_branch_taken;
        end
      end
      if (!pc_write && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus random
// stimulus compared against a rule-level reference model.
module tb_hazard_stall_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ID_rs, ID_rt, EX_rt;
  logic          ID_uses_rt, ID_jump, EX_mem_read, EX_branch_taken, imem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, fetch_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_err;
  int m_low;
  bit m_pend;
  bit m_lu_served;
  int m_stall;
  int m_flush;

  hazard_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_jump(ID_jump),
    .EX_mem_read(EX_mem_read), .EX_rt(EX_rt), .EX_branch_taken(EX_branch_taken),
    .imem_ready(imem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .fetch_err(fetch_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic lu_raw();
    return EX_mem_read && EX_rt != 5'd0 &&
           (EX_rt == ID_rs || (ID_uses_rt && EX_rt == ID_rt));
  endfunction

  // {stall caused by load-use, pc_write, if_id_write, if_id_flush, id_ex_bubble}
  function automatic logic [4:0] model_ctrl();
    if (!rst)                        return 5'b0_0011;
    if (m_err)                       return 5'b0_0011;
    if (EX_branch_taken)             return 5'b0_1111;
    if (!imem_ready)                 return 5'b0_0001;
    if (m_pend)                      return 5'b0_1111;
    if (lu_raw() && !m_lu_served)    return 5'b1_0001;
    if (ID_jump)                     return 5'b0_1110;
    return 5'b0_1100;
  endfunction

  task automatic model_reset();
    m_err = 0; m_low = 0; m_pend = 0; m_lu_served = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_advance();
    logic [4:0] e;
    bit         raw;
    e   = model_ctrl();
    raw = lu_raw();
    if (!rst) begin
      model_reset();
      return;
    end
    if (!e[3] && m_stall < CMAX) m_stall++;
    if (e[1] && m_flush < CMAX) m_flush++;
    m_lu_served = raw && (m_lu_served || e[4]);
    if (!m_err) begin
      if (!imem_ready) begin
        m_low++;
        if (EX_branch_taken) m_pend = 1;
        if (m_low >= TO) m_err = 1;
      end else begin
        m_low  = 0;
        m_pend = 0;
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_idle();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
    ID_uses_rt = 1'b0; ID_jump = 1'b0; EX_mem_read = 1'b0;
    EX_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  function automatic logic [3:0] act_ctrl();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    set_idle();
    model_reset();
    tick(); tick();
    #2;
    n_checks++; if (act_ctrl() !== 4'b0011) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0011", act_ctrl()); end
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_err: got %b expected 0", fetch_err); end
    n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    n_checks++; if (flush_cnt !== '0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
    rst = 1'b1;
    #1;
    n_checks++; if (act_ctrl() !== 4'b1100) begin n_fail++; $display("FAIL reset_release_ctrl: got %b expected 1100", act_ctrl()); end
    tick();
  endtask

  task automatic test_load_use();
    int s0;
    s0 = m_stall;
    EX_mem_read = 1'b1; EX_rt = 5'd8; ID_rs = 5'd8;
    #2;
    n_checks++; if (act_ctrl() !== 4'b0001) begin n_fail++; $display("FAIL load_use_stall: got %b expected 0001", act_ctrl()); end
    tick();
    set_idle();
    #2;
    n_checks++; if (stall_cnt !== CW'(s0 + 1)) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d expected %0d", stall_cnt, s0 + 1); end
    tick();
    EX_mem_read = 1'b1; EX_rt = 5'd0; ID_rs = 5'd0;
    #2;
    n_checks++; if (act_ctrl() !== 4'b1100) begin n_fail++; $display("FAIL load_use_r0: got %b expected 1100", act_ctrl()); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_rt_hazard();
    EX_mem_read = 1'b1; EX_rt = 5'd9; ID_rt = 5'd9; ID_rs = 5'd1; ID_uses_rt = 1'b0;
    #2;
    n_checks++; if (act_ctrl() !== 4'b1100) begin n_fail++; $display("FAIL rt_unused: got %b expected 1100", act_ctrl()); end
    tick();
    ID_uses_rt = 1'b1;
    #2;
    n_checks++; if (act_ctrl() !== 4'b0001) begin n_fail++; $display("FAIL rt_used_stall: got %b expected 0001", act_ctrl()); end
    tick();
    #2;
    n_checks++; if (act_ctrl() !== 4'b1100) begin n_fail++; $display("FAIL rt_single_stall: got %b expected 1100", act_ctrl()); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_branch_wait();
    int f0;
    f0 = m_flush;
    imem_ready = 1'b0;
    #2;
    n_checks++; if (act_ctrl() !== 4'b0001) begin n_fail++; $display("FAIL bw_c1: got %b expected 0001", act_ctrl()); end
    tick();
    EX_branch_taken = 1'b1;
    #2;
    n_checks++; if (act_ctrl() !== 4'b1111) begin n_fail++; $display("FAIL bw_c2_branch: got %b expected 1111", act_ctrl()); end
    tick();
    EX_branch_taken = 1'b0;
    #2;
    n_checks++; if (act_ctrl() !== 4'b0001) begin n_fail++; $display("FAIL bw_c3: got %b expected 0001", act_ctrl()); end
    tick();
    imem_ready = 1'b1;
    #2;
    n_checks++; if (act_ctrl() !== 4'b1111) begin n_fail++; $display("FAIL bw_pend_flush: got %b expected 1111", act_ctrl()); end
    tick();
    #2;
    n_checks++; if (act_ctrl() !== 4'b1100) begin n_fail++; $display("FAIL bw_after: got %b expected 1100", act_ctrl()); end
    n_checks++; if (flush_cnt !== CW'(f0 + 2)) begin n_fail++; $display("FAIL bw_flush_cnt: got %0d expected %0d", flush_cnt, f0 + 2); end
    tick();
  endtask

  task automatic test_jump_lu();
    ID_jump = 1'b1; EX_mem_read = 1'b1; EX_rt = 5'd3; ID_rs = 5'd3;
    #2;
    n_checks++; if (act_ctrl() !== 4'b0001) begin n_fail++; $display("FAIL jump_lu_stall: got %b expected 0001", act_ctrl()); end
    tick();
    EX_mem_read = 1'b0;
    #2;
    n_checks++; if (act_ctrl() !== 4'b1110) begin n_fail++; $display("FAIL jump_lu_flush: got %b expected 1110", act_ctrl()); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int i = 0; i < 400; i++) begin
      EX_mem_read     = ($urandom_range(0, 2) == 0);
      EX_rt           = 5'($urandom_range(0, 3));
      ID_rs           = 5'($urandom_range(0, 3));
      ID_rt           = 5'($urandom_range(0, 3));
      ID_uses_rt      = 1'($urandom_range(0, 1));
      ID_jump         = ($urandom_range(0, 5) == 0);
      EX_branch_taken = ($urandom_range(0, 7) == 0);
      imem_ready      = ($urandom_range(0, 4) != 0) || (m_low >= TO - 1);
      #2;
      e = model_ctrl();
      n_checks++; if (act_ctrl() !== e[3:0]) begin n_fail++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, act_ctrl(), e[3:0]); end
      n_checks++; if (stall_cnt !== CW'(m_stall)) begin n_fail++; $display("FAIL rand_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, m_stall); end
      n_checks++; if (flush_cnt !== CW'(m_flush)) begin n_fail++; $display("FAIL rand_flush_cnt[%0d]: got %0d expected %0d", i, flush_cnt, m_flush); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL rand_fetch_err[%0d]: got %b expected 0", i, fetch_err); end
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_timeout();
    imem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #2;
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL to_early_err[%0d]: got %b expected 0", i, fetch_err); end
      n_checks++; if (act_ctrl() !== 4'b0001) begin n_fail++; $display("FAIL to_wait_ctrl[%0d]: got %b expected 0001", i, act_ctrl()); end
      tick();
    end
    imem_ready = 1'b1;
    #2;
    n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL to_fetch_err: got %b expected 1", fetch_err); end
    n_checks++; if (act_ctrl() !== 4'b0011) begin n_fail++; $display("FAIL to_err_ctrl: got %b expected 0011", act_ctrl()); end
    repeat (40) tick();
    #2;
    n_checks++; if (stall_cnt !== CW'(CMAX)) begin n_fail++; $display("FAIL to_stall_sat: got %0d expected %0d", stall_cnt, CMAX); end
    n_checks++; if (flush_cnt !== CW'(m_flush)) begin n_fail++; $display("FAIL to_flush_cnt: got %0d expected %0d", flush_cnt, m_flush); end
    n_checks++; if (fetch_err !== 1'b1 || pc_write !== 1'b0) begin n_fail++; $display("FAIL to_sticky: got err=%b pc=%b expected err=1 pc=0", fetch_err, pc_write); end
  endtask

  task automatic test_async_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    imem_ready = 1'b0;
    tick();
    EX_branch_taken = 1'b1;
    tick();
    EX_branch_taken = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (act_ctrl() !== 4'b0011) begin n_fail++; $display("FAIL ar_ctrl: got %b expected 0011", act_ctrl()); end
    n_checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_fail++; $display("FAIL ar_counters: got stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt); end
    n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL ar_fetch_err: got %b expected 0", fetch_err); end
    model_reset();
    #1;
    rst = 1'b1;
    imem_ready = 1'b1;
    #1;
    n_checks++; if (act_ctrl() !== 4'b1100) begin n_fail++; $display("FAIL ar_release_ctrl: got %b expected 1100", act_ctrl()); end
    tick();
    #2;
    n_checks++; if (act_ctrl() !== 4'b1100) begin n_fail++; $display("FAIL ar_no_pend: got %b expected 1100", act_ctrl()); end
    n_checks++; if (stall_cnt !== CW'(m_stall)) begin n_fail++; $display("FAIL ar_stall_after: got %0d expected %0d", stall_cnt, m_stall); end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    test_reset();
    test_load_use();
    test_rt_hazard();
    test_branch_wait();
    test_jump_lu();
    test_random();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
